// File: rtl/fetch_if.sv
// Bundles the fetch-stage signals: the instruction-memory request/response
// pair and the held instruction plus retirement controls shared with the
// control unit.
//
// Handshake: a fetch completes on the rising edge that ends a cycle where
// imem_req=1 and imem_valid=1. imem_req and imem_addr stay stable until
// then. imem_valid seen while imem_req=0 carries no meaning. A held
// instruction retires on the rising edge that ends a cycle where
// instr_valid=1 and instr_ack=1.
//
// Modports:
//   master : fetch unit side (drives request, held instruction, pc, halted)
//   slave  : memory / control-unit side
interface fetch_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic        instr_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        instr_ack;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;
    logic [1:0]  fsm_state;    // debug view of the fetch FSM

    modport master (
        output imem_req, imem_addr, instr, opcode, instr_valid,
               pc, pc_plus2, halted, fsm_state,
        input  imem_rdata, imem_valid, instr_ack, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, opcode, instr_valid,
               pc, pc_plus2, halted, fsm_state,
        output imem_rdata, imem_valid, instr_ack, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the unpipelined 16-bit processor.
// Owns the PC, fetches one instruction word at a time over a req/valid
// handshake, holds it for the control unit until it retires, then moves
// the PC on sequentially or to a redirect target. A retired HALT stops
// fetching until reset.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : fetch_if.master (memory request/response, held instruction,
//          pc / pc_plus2, retirement controls, halted, fsm_state debug)
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [4:0]  HALT_OPC = 5'b00000,
    parameter logic [15:0] NOP_WORD = 16'h0800
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.master bus
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [15:0] pc_q, pc_next;
    logic [15:0] instr_q, instr_next;
    logic        valid_q, valid_next;
    logic        halted_q, halted_next;
    logic        req_q;
    logic        capture;
    logic        retire;

    assign capture = req_q && bus.imem_valid;
    assign retire  = valid_q && bus.instr_ack;

    always_comb begin
        state_next  = state;
        pc_next     = pc_q;
        instr_next  = instr_q;
        valid_next  = valid_q;
        halted_next = halted_q;
        case (state)
            FETCH: begin
                if (capture) begin
                    instr_next = bus.imem_rdata;
                    valid_next = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (retire) begin
                    valid_next = 1'b0;
                    instr_next = NOP_WORD;
                    if (instr_q[15:11] == HALT_OPC) begin
                        // pc stays on the HALT so software can see where it stopped
                        state_next  = HALTED;
                        halted_next = 1'b1;
                    end else begin
                        state_next = FETCH;
                        pc_next    = bus.redirect_valid ? (bus.redirect_pc & 16'hFFFE)
                                                        : pc_q + 16'd2;
                    end
                end
            end
            HALTED: begin
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state    <= state_next;
            pc_q     <= pc_next;
            instr_q  <= instr_next;
            valid_q  <= valid_next;
            halted_q <= halted_next;
            // Request is registered: it rises the cycle after we enter (or stay in)
            // FETCH, so the first request after reset lands one cycle after release.
            req_q    <= (state_next == FETCH);
        end
    end

    // Masking with rst keeps the request low in the first reset cycle too,
    // which the register alone cannot guarantee.
    assign bus.imem_req    = req_q && !rst;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[15:11];
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus2    = pc_q + 16'd2;
    assign bus.halted      = halted_q;
    assign bus.fsm_state   = state;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [4:0]  HALT_OPC = 5'b00000;
    localparam logic [15:0] NOP_WORD = 16'h0800;

    logic clk;
    logic rst;
    fetch_if bus ();

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .HALT_OPC(HALT_OPC),
        .NOP_WORD(NOP_WORD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model: what the fetch stage must present after each edge
    logic [15:0] m_pc, m_instr;
    logic        m_valid, m_halted, m_req;
    logic        model_ok = 1'b0;
    logic [15:0] mem [256];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_update();
        if (rst) begin
            m_pc = RESET_PC; m_instr = NOP_WORD;
            m_valid = 1'b0; m_halted = 1'b0; m_req = 1'b0;
            model_ok = 1'b1;
        end else if (!model_ok || m_halted) begin
            // nothing moves
        end else if (m_valid) begin
            if (bus.instr_ack) begin
                m_valid = 1'b0;
                if (m_instr[15:11] == HALT_OPC) m_halted = 1'b1;
                else begin
                    m_pc  = bus.redirect_valid ? {bus.redirect_pc[15:1], 1'b0} : m_pc + 16'd2;
                    m_req = 1'b1;
                end
                m_instr = NOP_WORD;
            end
        end else begin
            if (m_req && bus.imem_valid) begin
                m_instr = bus.imem_rdata; m_valid = 1'b1; m_req = 1'b0;
            end else m_req = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // compare process: every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (model_ok) begin
            chk("imem_req",    {15'b0, bus.imem_req},    {15'b0, m_req && !rst});
            chk("imem_addr",   bus.imem_addr,            m_pc);
            chk("pc",          bus.pc,                   m_pc);
            chk("pc_plus2",    bus.pc_plus2,             m_pc + 16'd2);
            chk("instr",       bus.instr,                m_instr);
            chk("opcode",      {11'b0, bus.opcode},      {11'b0, m_instr[15:11]});
            chk("instr_valid", {15'b0, bus.instr_valid}, {15'b0, m_valid});
            chk("halted",      {15'b0, bus.halted},      {15'b0, m_halted});
        end
    end

    // driver tasks
    task automatic do_fetch(input logic [15:0] w, input int wait_cycles);
        int n;
        bus.imem_valid = 1'b0;
        bus.instr_ack  = 1'b0;
        n = 0;
        while (!m_req && n < 8) begin tick(); n++; end
        if (!m_req) chk("fetch_req_timeout", 16'd0, 16'd1);
        repeat (wait_cycles) tick();
        bus.imem_rdata = w;
        bus.imem_valid = 1'b1;
        tick();
        bus.imem_valid = 1'b0;
    endtask

    task automatic retire(input logic redir, input logic [15:0] tgt);
        bus.instr_ack      = 1'b1;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        tick();
        bus.instr_ack      = 1'b0;
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (w[15:11] == HALT_OPC) w[11] = ~w[11];
            mem[i] = w;
        end
        mem[37] = 16'h0000;   // an occasional HALT for the random phase

        rst = 1'b1;
        bus.imem_valid = 1'b0; bus.imem_rdata = 16'h0;
        bus.instr_ack = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 16'h0;
        tick(); tick();

        // zero-wait fetch after reset
        rst = 1'b0; #1;
        chk("t1_req_cycle0", {15'b0, bus.imem_req}, 16'd0);
        chk("t1_halted_rst", {15'b0, bus.halted}, 16'd0);
        tick();
        chk("t1_req_cycle1", {15'b0, bus.imem_req}, 16'd1);
        chk("t1_addr_cycle1", bus.imem_addr, 16'h0000);
        bus.imem_rdata = 16'hC001; bus.imem_valid = 1'b1;
        tick();
        bus.imem_valid = 1'b0;
        chk("t1_valid_cycle2", {15'b0, bus.instr_valid}, 16'd1);
        chk("t1_opcode", {11'b0, bus.opcode}, 16'b11000);
        chk("t1_pc", bus.pc, 16'h0000);
        retire(1'b0, 16'h0);
        chk("t1_next_addr", bus.imem_addr, 16'h0002);
        chk("t1_next_req", {15'b0, bus.imem_req}, 16'd1);
        chk("t1_instr_nop", bus.instr, 16'h0800);

        // 3-cycle memory, then a spurious valid during HOLD
        do_fetch(16'h1234, 2);
        chk("t2_instr", bus.instr, 16'h1234);
        bus.imem_rdata = 16'hFFFF; bus.imem_valid = 1'b1;
        tick();
        bus.imem_valid = 1'b0;
        chk("t2_instr_held", bus.instr, 16'h1234);
        chk("t2_pc_held", bus.pc, 16'h0002);

        // redirect alignment and sequential wrap
        retire(1'b1, 16'h0123);
        chk("t3_redirect_pc", bus.pc, 16'h0122);
        do_fetch(16'h2000, 0);
        retire(1'b1, 16'hFFFF);
        chk("t3_pc_fffe", bus.pc, 16'hFFFE);
        do_fetch(16'h2000, 1);
        retire(1'b0, 16'h0);
        chk("t3_wrap_pc", bus.pc, 16'h0000);
        chk("t3_wrap_plus2", bus.pc_plus2, 16'h0002);
        chk("t3_model_wrap", m_pc, 16'h0000);

        // HALT at 0x0010
        do_fetch(16'h2000, 0);
        retire(1'b1, 16'h0010);
        do_fetch(16'h0000, 1);
        retire(1'b0, 16'h0);
        chk("t4_halted", {15'b0, bus.halted}, 16'd1);
        chk("t4_pc", bus.pc, 16'h0010);
        for (int i = 0; i < 20; i++) begin
            bus.imem_valid = 1'($urandom_range(0, 1));
            bus.imem_rdata = 16'($urandom);
            bus.instr_ack = 1'($urandom_range(0, 1));
            bus.redirect_valid = 1'($urandom_range(0, 1));
            bus.redirect_pc = 16'($urandom);
            tick();
            chk("t4_req_low", {15'b0, bus.imem_req}, 16'd0);
            chk("t4_pc_stays", bus.pc, 16'h0010);
        end
        bus.imem_valid = 1'b0; bus.instr_ack = 1'b0; bus.redirect_valid = 1'b0;

        // reset during a fetch wait, with a response in the same cycle and a late one
        rst = 1'b1; tick();
        rst = 1'b0; tick(); tick(); tick();
        rst = 1'b1;
        bus.imem_rdata = 16'h5555; bus.imem_valid = 1'b1;
        #1;
        chk("t5_req_in_rst", {15'b0, bus.imem_req}, 16'd0);
        tick();
        chk("t5_pc", bus.pc, RESET_PC);
        chk("t5_instr", bus.instr, 16'h0800);
        rst = 1'b0; #1;
        chk("t5_req_after_rst", {15'b0, bus.imem_req}, 16'd0);
        tick();
        bus.imem_valid = 1'b0;
        chk("t5_late_ignored", {15'b0, bus.instr_valid}, 16'd0);
        chk("t5_late_instr", bus.instr, 16'h0800);
        // reset in a cycle with instr_ack
        do_fetch(16'h3000, 0);
        bus.instr_ack = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h4444;
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.instr_ack = 1'b0; bus.redirect_valid = 1'b0;
        chk("t5_ack_rst_pc", bus.pc, RESET_PC);
        chk("t5_ack_rst_valid", {15'b0, bus.instr_valid}, 16'd0);
        chk("t5_ack_rst_instr", bus.instr, 16'h0800);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            if (m_req) begin
                bus.imem_valid = ($urandom_range(0, 2) == 0);
                bus.imem_rdata = mem[m_pc[8:1]];
            end else begin
                bus.imem_valid = ($urandom_range(0, 9) == 0);
                bus.imem_rdata = 16'($urandom);
            end
            bus.instr_ack      = ($urandom_range(0, 2) == 0);
            bus.redirect_valid = 1'($urandom_range(0, 1));
            bus.redirect_pc    = 16'($urandom);
            tick();
        end

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the unpipelined 16-bit processor. It owns the PC, requests instruction words from instruction memory with a req/valid handshake, and holds the fetched word and its 5-bit opcode stable for the control unit and datapath until the current instruction retires. At retirement it advances the PC sequentially or to a redirect target supplied by branch/jump logic. A HALT opcode stops fetching.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.
HALT_OPC, 5'b00000, opcode that stops fetching after it retires.
NOP_WORD, 16'h0800, instruction word (opcode 5'b00001, NOP) presented while no valid instruction is held.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
imem_req  out  1  instruction-memory read request.
imem_addr  out  16  byte address of the word being fetched; always equals pc.
imem_rdata  in  16  instruction word from memory.
imem_valid  in  1  imem_rdata is valid this cycle; only meaningful while imem_req=1.
instr  out  16  held instruction word, to the control unit and datapath.
opcode  out  5  instr[15:11], to the control unit.
instr_valid  out  1  instr/opcode hold a fetched instruction.
pc  out  16  address of the held or in-flight instruction.
pc_plus2  out  16  pc+2, modulo 2^16 (link value / branch base).
instr_ack  in  1  the current instruction retires this cycle.
redirect_valid  in  1  with instr_ack: the next PC comes from redirect_pc.
redirect_pc  in  16  branch/jump target.
halted  out  1  a HALT has retired; fetching has stopped.

Behaviour:
- States: FETCH, HOLD, HALTED. FETCH is entered on reset.
- Reset values:
  - pc=RESET_PC.
  - instr=NOP_WORD, so opcode=5'b00001.
  - instr_valid=0, halted=0.
  - imem_req=0 in every cycle in which rst=1. imem_req is a registered output. The first request is issued in the cycle after rst deasserts.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until a cycle in which imem_valid=1.
  - Zero-wait memory (imem_valid=1 in the first request cycle) is legal.
  - On the edge ending a cycle with imem_req&&imem_valid: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to HOLD.
  - Minimum latency from request to instr_valid is 1 cycle.
- imem_valid while imem_req=0 is ignored.
- HOLD:
  - instr, opcode and pc are stable; imem_req=0.
  - instr_ack is ignored when instr_valid=0.
  - On the edge ending a cycle with instr_ack=1: instr_valid<=0 and instr<=NOP_WORD.
  - If opcode==HALT_OPC: go to HALTED, halted<=1, pc unchanged (points at the HALT).
  - Else if redirect_valid=1: pc<={redirect_pc[15:1],1'b0} (bit 0 forced to 0). Go to FETCH, with imem_req=1 in the next cycle.
  - Else: pc<=pc+2, wrapping 16'hFFFE to 16'h0000. Go to FETCH, with imem_req=1 in the next cycle.
- redirect_valid/redirect_pc are sampled only when instr_ack=1 in HOLD; they are ignored otherwise.
- HALTED: imem_req=0 and instr_valid=0 permanently, all inputs ignored. Only rst exits HALTED.
- rst has priority over every other event in every state, including a cycle with imem_valid or instr_ack. A response that is outstanding when reset asserts is discarded. The memory must drop imem_valid once imem_req=0.
- pc_plus2 is combinational from pc and has no reset dependency beyond pc.

Test Plan:
- Reset then 0-wait memory returning 16'hC001 at address 0 -> imem_req=1 in cycle 1; instr_valid=1, opcode=5'b11000, pc=0 in cycle 2; ack -> next imem_addr=16'h0002.
- Memory with 3-cycle latency -> imem_req held 3 cycles with imem_addr constant; instr captured only on the imem_valid cycle; spurious imem_valid pulse during HOLD has no effect.
- Ack with redirect_valid=1, redirect_pc=16'h0123 -> pc=16'h0122; without redirect, pc 16'hFFFE + ack -> pc=16'h0000, pc_plus2=16'h0002.
- Fetch 16'h0000 (HALT) at pc=16'h0010, ack -> halted=1, pc stays 16'h0010, imem_req stays 0 for 20 cycles despite imem_valid/instr_ack toggling.
- rst asserted during a FETCH wait and again in a cycle with instr_ack=1 -> pc=RESET_PC, instr=16'h0800, instr_valid=0, imem_req=0 during reset; late imem_valid is not captured.
